// File: rtl/me_host_pkg.sv
// Shared types and defaults for the modular-exponentiation operand host.
// Holds the host FSM state encoding and the word-index width helper.
package me_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Y,
        START,
        LOAD_X,
        WAIT_RES,
        DONE
    } me_state_t;

    localparam int DEF_K           = 128;
    localparam int DEF_N           = 16;
    localparam int DEF_TIMEOUT_CYC = 2 ** 24;

    // Index width for n words; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/me_word_shifter.sv
// Parallel-load, serial-out word register: word 0 is presented first,
// each shift moves the next-higher word down and fills the top with zeros.
module me_word_shifter #(
    parameter int K = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [K*N-1:0] load_data,
    output logic [K-1:0]   word
);

    logic [K-1:0] word_reg  [N];
    logic [K-1:0] word_next [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            logic [K-1:0] upper;
            if (gi == N - 1) begin : g_top
                assign upper = '0;
            end else begin : g_mid
                assign upper = word_reg[gi+1];
            end
            assign word_next[gi] = load  ? load_data[gi*K +: K] :
                                   shift ? upper : word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                word_reg[i] <= '0;
            end
        end else begin
            word_reg <= word_next;
        end
    end

    assign word = word_reg[0];

endmodule

// File: rtl/me_iddmm_host.sv
// Operand host for me_iddmm_top: serialises one (x, y) job into the engine,
// pulses start, collects N result words and guards each with a watchdog.
module me_iddmm_host
    import me_host_pkg::*;
#(
    parameter int K           = DEF_K,
    parameter int N           = DEF_N,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [K*N-1:0] op_x,
    input  logic [K*N-1:0] op_y,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [K*N-1:0] res_data,
    output logic           res_timeout,
    output logic           busy,
    output logic           me_start,
    output logic [K-1:0]   me_x,
    output logic           me_x_valid,
    output logic [K-1:0]   me_y,
    output logic           me_y_valid,
    input  logic [K-1:0]   me_result,
    input  logic           me_valid
);

    localparam int            CW   = idx_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    me_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [TW-1:0] wd_reg, wd_next;
    logic          res_timeout_reg, res_timeout_next;
    logic          op_ready_reg, busy_reg, res_valid_reg;
    logic          me_start_reg, me_x_valid_reg, me_y_valid_reg;
    logic          accept, res_wr;

    assign accept = op_valid & op_ready_reg;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        wd_next          = wd_reg;
        res_timeout_next = res_timeout_reg;
        res_wr           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD_Y;
                    cnt_next   = '0;
                end
            end
            LOAD_Y: begin
                if (cnt_reg == LAST) begin
                    state_next = START;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            START: state_next = LOAD_X;
            LOAD_X: begin
                if (cnt_reg == LAST) begin
                    state_next = WAIT_RES;
                    cnt_next   = '0;
                    wd_next    = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_RES: begin
                if (me_valid) begin
                    res_wr  = 1'b1;
                    wd_next = '0;
                    if (cnt_reg == LAST) begin
                        state_next       = DONE;
                        res_timeout_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (wd_reg == TW'(TIMEOUT_CYC - 1)) begin
                    // Engine went quiet: hand back whatever words arrived.
                    state_next       = DONE;
                    res_timeout_next = 1'b1;
                end else begin
                    wd_next = wd_reg + TW'(1);
                end
            end
            DONE: begin
                if (res_valid_reg && res_ready) begin
                    state_next       = IDLE;
                    res_timeout_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state's decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            wd_reg          <= '0;
            res_timeout_reg <= 1'b0;
            op_ready_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            res_valid_reg   <= 1'b0;
            me_start_reg    <= 1'b0;
            me_x_valid_reg  <= 1'b0;
            me_y_valid_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            wd_reg          <= wd_next;
            res_timeout_reg <= res_timeout_next;
            op_ready_reg    <= (state_next == IDLE);
            busy_reg        <= (state_next != IDLE);
            res_valid_reg   <= (state_next == DONE);
            me_start_reg    <= (state_next == START);
            me_x_valid_reg  <= (state_next == LOAD_X);
            me_y_valid_reg  <= (state_next == LOAD_Y);
        end
    end

    me_word_shifter #(.K(K), .N(N)) u_y_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (state_reg == LOAD_Y),
        .load_data (op_y),
        .word      (me_y)
    );

    me_word_shifter #(.K(K), .N(N)) u_x_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (state_reg == LOAD_X),
        .load_data (op_x),
        .word      (me_x)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_res
            logic [K-1:0] word_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (accept) begin
                    word_reg <= '0;
                end else if (res_wr && (cnt_reg == CW'(gi))) begin
                    word_reg <= me_result;
                end
            end
            assign res_data[gi*K +: K] = word_reg;
        end
    endgenerate

    assign op_ready    = op_ready_reg;
    assign busy        = busy_reg;
    assign res_valid   = res_valid_reg;
    assign res_timeout = res_timeout_reg;
    assign me_start    = me_start_reg;
    assign me_x_valid  = me_x_valid_reg;
    assign me_y_valid  = me_y_valid_reg;

endmodule

// File: tb/tb_me_iddmm_host.sv
// Self-checking bench for me_iddmm_host (K=8, N=4, TIMEOUT_CYC=50) with an
// XOR engine responder and a scoreboard of expected results.
module tb_me_iddmm_host;

    localparam int K  = 8;
    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [K*N-1:0] op_x, op_y;
    logic           res_valid, res_ready, res_timeout, busy;
    logic [K*N-1:0] res_data;
    logic           me_start, me_x_valid, me_y_valid, me_valid;
    logic [K-1:0]   me_x, me_y, me_result;

    me_iddmm_host #(.K(K), .N(N), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_x        (op_x),
        .op_y        (op_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .busy        (busy),
        .me_start    (me_start),
        .me_x        (me_x),
        .me_x_valid  (me_x_valid),
        .me_y        (me_y),
        .me_y_valid  (me_y_valid),
        .me_result   (me_result),
        .me_valid    (me_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [K*N-1:0] data;
        logic           to;
    } exp_t;
    exp_t exp_q[$];

    // Reference: word i = x_i ^ y_i for the first nw words, zero above.
    function automatic logic [K*N-1:0] model(input logic [K*N-1:0] x,
                                             input logic [K*N-1:0] y,
                                             input int nw);
        logic [K*N-1:0] r;
        r = '0;
        for (int i = 0; i < nw; i++) r[i*K +: K] = x[i*K +: K] ^ y[i*K +: K];
        return r;
    endfunction

    // Engine responder: captures y/x streams, answers 10 cycles after the last x.
    int           resp_words = N;
    int           resp_last_cyc = 0;
    int           inj_req = 0;
    logic [K-1:0] inj_data = '0;

    initial begin
        logic [K-1:0] xs[N];
        logic [K-1:0] ys[N];
        int rx, ry, delay, sent, inj_done;
        bit sending, prev_yv;
        me_valid = 1'b0; me_result = '0;
        rx = 0; ry = 0; delay = 0; sent = 0; inj_done = 0;
        sending = 0; prev_yv = 0;
        for (int i = 0; i < N; i++) begin xs[i] = '0; ys[i] = '0; end
        forever begin
            @(negedge clk);
            me_valid = 1'b0;
            if (rst) begin
                rx = 0; ry = 0; delay = 0; sending = 0; prev_yv = 0;
            end else begin
                if (delay > 0) begin
                    delay--;
                    if (delay == 0) begin sending = 1; sent = 0; end
                end
                if (sending) begin
                    if (sent < resp_words) begin
                        me_valid = 1'b1;
                        me_result = xs[sent] ^ ys[sent];
                        sent++;
                        resp_last_cyc = cyc;
                    end else begin
                        sending = 0;
                    end
                end else if (inj_req != inj_done) begin
                    me_valid = 1'b1;
                    me_result = inj_data;
                    inj_done++;
                end
                if (me_y_valid) begin
                    if (!prev_yv) begin ry = 0; rx = 0; end
                    if (ry < N) ys[ry] = me_y;
                    ry++;
                end
                prev_yv = me_y_valid;
                if (me_x_valid) begin
                    if (rx < N) xs[rx] = me_x;
                    rx++;
                    if (rx == N) delay = 10;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic wait_res(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (res_valid === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic launch(input logic [K*N-1:0] x, input logic [K*N-1:0] y,
                          input int nw, input logic to);
        exp_t e;
        op_x = x; op_y = y; op_valid = 1'b1;
        e.data = model(x, y, nw); e.to = to;
        exp_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({op_ready, busy, res_valid, res_timeout, me_start, me_x_valid, me_y_valid,
             res_data, me_x, me_y} !== {1'b1, 6'b0, 48'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b rv=%b data=%h x=%h y=%h required rdy=1 rest 0",
                     op_ready, busy, res_valid, res_data, me_x, me_y);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b required rdy=1 busy=0", op_ready, busy);
        end
    endtask

    task automatic test_basic;
        logic [K*N-1:0] x, y;
        exp_t e;
        bit ok;
        x = 32'h04030201; y = 32'h40302010;
        $display("basic: x=%h y=%h", x, y);
        op_x = x; op_y = y; op_valid = 1'b1;
        e.data = model(x, y, N); e.to = 1'b0;
        exp_q.push_back(e);
        for (int c = 1; c <= 2 * N + 1; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
            checks++;
            if (me_y_valid !== (c <= N) || (c <= N && me_y !== y[(c-1)*K +: K])) begin
                errors++;
                $display("FAIL basic_y c=%0d: got v=%b y=%h required v=%b", c, me_y_valid, me_y, c <= N);
            end
            checks++;
            if (me_start !== (c == N + 1)) begin
                errors++;
                $display("FAIL basic_start c=%0d: got %b required %b", c, me_start, c == N + 1);
            end
            checks++;
            if (me_x_valid !== (c >= N + 2) || (c >= N + 2 && me_x !== x[(c-N-2)*K +: K])) begin
                errors++;
                $display("FAIL basic_x c=%0d: got v=%b x=%h required v=%b", c, me_x_valid, me_x, c >= N + 2);
            end
        end
        wait_res(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_wait: got no res_valid required res_valid within 300 cycles");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e.data || res_timeout !== e.to) begin
                errors++;
                $display("FAIL basic_result: got %h/%b required %h/%b", res_data, res_timeout, e.data, e.to);
            end
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: got rv=%b rdy=%b required rv=0 rdy=1", res_valid, op_ready);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit ok;
        res_ready = 1'b0;
        launch(32'hA1B2C3D4, 32'h0F1E2D3C, N, 1'b0);
        $display("backpressure: job launched");
        wait_res(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_wait: got no res_valid required res_valid within 300 cycles");
        end else begin
            e = exp_q.pop_front();
            op_valid = 1'b1; op_x = 32'hDEADBEEF; op_y = 32'h12345678;
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== e.data || op_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold i=%0d: got rv=%b data=%h rdy=%b required rv=1 data=%h rdy=0",
                             i, res_valid, res_data, op_ready, e.data);
                end
                @(negedge clk);
            end
        end
        op_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got rv=%b busy=%b rdy=%b required 0/0/1", res_valid, busy, op_ready);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        bit ok;
        resp_words = 2;
        launch(32'h04030201, 32'h40302010, 2, 1'b1);
        $display("timeout: responder sends 2 words");
        wait_res(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL to_wait: got no res_valid required res_valid within 300 cycles");
        end else begin
            // Registered status: res_valid shows one cycle after the 50th idle cycle.
            checks++;
            if (cyc - resp_last_cyc != TO + 1) begin
                errors++;
                $display("FAIL to_latency: got %0d cycles required %0d", cyc - resp_last_cyc, TO + 1);
            end
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e.data || res_timeout !== e.to || e.data !== 32'h00002211) begin
                errors++;
                $display("FAIL to_result: got %h/%b required %h/1", res_data, res_timeout, 32'h00002211);
            end
        end
        @(negedge clk);
        checks++;
        if (res_timeout !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got to=%b rv=%b required 0/0", res_timeout, res_valid);
        end
        resp_words = N;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit ok;
        op_x = 32'h11223344; op_y = 32'h55667788; op_valid = 1'b1;
        repeat (7) begin @(negedge clk); op_valid = 1'b0; end
        checks++;
        if (me_x_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_in_loadx: got me_x_valid=%b required 1", me_x_valid);
        end
        #1 rst = 1'b1;
        $display("reset_mid: reset asserted in LOAD_X");
        @(posedge clk);
        #1;
        checks++;
        if ({op_ready, busy, res_valid, res_timeout, me_start, me_x_valid, me_y_valid,
             res_data, me_x, me_y} !== {1'b1, 6'b0, 48'b0}) begin
            errors++;
            $display("FAIL rmid_state: got rdy=%b busy=%b xv=%b x=%h y=%h data=%h required rdy=1 rest 0",
                     op_ready, busy, me_x_valid, me_x, me_y, res_data);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        launch(32'hCAFE0102, 32'h0BADF00D, N, 1'b0);
        wait_res(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rmid_wait: got no res_valid required res_valid within 300 cycles");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e.data || res_timeout !== e.to) begin
                errors++;
                $display("FAIL rmid_result: got %h/%b required %h/%b", res_data, res_timeout, e.data, e.to);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [K*N-1:0] xb, yb;
        exp_t e, eb;
        bit ok;
        xb = 32'h89ABCDEF; yb = 32'h76543210;
        op_x = 32'h13579BDF; op_y = 32'h2468ACE0; op_valid = 1'b1;
        e.data = model(op_x, op_y, N); e.to = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        op_x = xb; op_y = yb;
        eb.data = model(xb, yb, N); eb.to = 1'b0;
        exp_q.push_back(eb);
        $display("back_to_back: job A accepted, job B queued");
        wait_res(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_wait_a: got no res_valid required res_valid within 300 cycles");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e.data) begin
                errors++;
                $display("FAIL b2b_result_a: got %h required %h", res_data, e.data);
            end
        end
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got rdy=%b busy=%b required 1/0", op_ready, busy);
        end
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (op_ready !== 1'b0 || me_y_valid !== 1'b1 || me_y !== yb[K-1:0]) begin
            errors++;
            $display("FAIL b2b_accept: got rdy=%b yv=%b y=%h required 0/1/%h",
                     op_ready, me_y_valid, me_y, yb[K-1:0]);
        end
        wait_res(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_wait_b: got no res_valid required res_valid within 300 cycles");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e.data) begin
                errors++;
                $display("FAIL b2b_result_b: got %h required %h", res_data, e.data);
            end
        end
        @(negedge clk);
        inj_data = 8'hEE; inj_req++;
        repeat (3) @(negedge clk);
        inj_data = 8'h5A; inj_req++;
        repeat (3) @(negedge clk);
        checks++;
        if (res_data !== eb.data || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_valid: got data=%h rv=%b busy=%b required %h/0/0",
                     res_data, res_valid, busy, eb.data);
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_x = '0; op_y = '0; res_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
